// File: rtl/fb_port_arbiter.sv
// Frame-buffer port arbiter: display fetch has absolute priority,
// camera writer and tracker reader share the remaining cycles round-robin.
module fb_port_arbiter #(
    parameter int H_RES  = 320,
    parameter int V_RES  = 240,
    parameter int ADDR_W = 17,
    parameter int DATA_W = 16
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_disp_req,
    input  logic [8:0]        i_disp_x,
    input  logic [7:0]        i_disp_y,
    output logic [DATA_W-1:0] o_disp_data,
    output logic              o_disp_valid,
    input  logic              i_wr_valid,
    output logic              o_wr_ready,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic              i_rd_valid,
    output logic              o_rd_ready,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic [DATA_W-1:0] o_rd_data,
    output logic              o_rd_data_valid,
    output logic              o_mem_en,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_wdata,
    input  logic [DATA_W-1:0] i_mem_rdata
);

    typedef enum logic [1:0] {
        TAG_NONE = 2'd0,
        TAG_DISP = 2'd1,
        TAG_TRK  = 2'd2
    } tag_e;

    localparam logic [ADDR_W-1:0] NPIX = ADDR_W'(H_RES * V_RES);

    logic              r_wr_turn;
    logic              r_mem_en;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    tag_e              r_tag1;
    tag_e              r_tag2;
    logic              r_zero1;
    logic              r_zero2;
    logic [DATA_W-1:0] r_disp_data;
    logic              r_disp_valid;
    logic [DATA_W-1:0] r_rd_data;
    logic              r_rd_valid;

    logic              w_disp_gnt;
    logic              w_wr_gnt;
    logic              w_rd_gnt;
    logic              w_disp_ok;
    logic              w_wr_ok;
    logic              w_rd_ok;
    logic [ADDR_W-1:0] w_disp_addr;
    logic              w_issue;
    logic              w_issue_we;
    logic [ADDR_W-1:0] w_issue_addr;
    tag_e              w_tag;
    logic              w_zero;
    logic [DATA_W-1:0] w_ret;

    // y*320 + x as shift-add: (y<<8) + (y<<6) + x
    assign w_disp_addr = (ADDR_W'(i_disp_y) << 8)
                       + (ADDR_W'(i_disp_y) << 6)
                       + ADDR_W'(i_disp_x);

    assign w_disp_ok = (i_disp_x < 9'(H_RES)) && (i_disp_y < 8'(V_RES));
    assign w_wr_ok   = i_wr_addr < NPIX;
    assign w_rd_ok   = i_rd_addr < NPIX;

    assign w_disp_gnt = i_rst_n && i_disp_req;

    always_comb begin
        w_wr_gnt = 1'b0;
        w_rd_gnt = 1'b0;
        if (i_rst_n && !i_disp_req) begin
            if (i_wr_valid && (!i_rd_valid || r_wr_turn)) begin
                w_wr_gnt = 1'b1;
            end else if (i_rd_valid) begin
                w_rd_gnt = 1'b1;
            end
        end
    end

    assign o_wr_ready = w_wr_gnt;
    assign o_rd_ready = w_rd_gnt;

    always_comb begin
        w_issue      = 1'b0;
        w_issue_we   = 1'b0;
        w_issue_addr = i_rd_addr;
        w_tag        = TAG_NONE;
        w_zero       = 1'b0;
        unique case (1'b1)
            w_disp_gnt: begin
                w_issue      = w_disp_ok;
                w_issue_addr = w_disp_addr;
                w_tag        = TAG_DISP;
                w_zero       = !w_disp_ok;
            end
            w_wr_gnt: begin
                w_issue      = w_wr_ok;
                w_issue_we   = w_wr_ok;
                w_issue_addr = i_wr_addr;
            end
            w_rd_gnt: begin
                w_issue = w_rd_ok;
                w_tag   = TAG_TRK;
                w_zero  = !w_rd_ok;
            end
            default: ;
        endcase
    end

    // Out-of-range reads still return, but as zero
    assign w_ret = r_zero2 ? '0 : i_mem_rdata;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_wr_turn    <= 1'b1;
            r_mem_en     <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_tag1       <= TAG_NONE;
            r_tag2       <= TAG_NONE;
            r_zero1      <= 1'b0;
            r_zero2      <= 1'b0;
            r_disp_data  <= '0;
            r_disp_valid <= 1'b0;
            r_rd_data    <= '0;
            r_rd_valid   <= 1'b0;
        end else begin
            r_mem_en <= w_issue;
            r_mem_we <= w_issue_we;
            if (w_issue) begin
                r_mem_addr <= w_issue_addr;
            end
            if (w_issue_we) begin
                r_mem_wdata <= i_wr_data;
            end
            if (w_wr_gnt) begin
                r_wr_turn <= 1'b0;
            end else if (w_rd_gnt) begin
                r_wr_turn <= 1'b1;
            end
            r_tag1       <= w_tag;
            r_zero1      <= w_zero;
            r_tag2       <= r_tag1;
            r_zero2      <= r_zero1;
            r_disp_valid <= (r_tag2 == TAG_DISP);
            r_rd_valid   <= (r_tag2 == TAG_TRK);
            if (r_tag2 == TAG_DISP) begin
                r_disp_data <= w_ret;
            end
            if (r_tag2 == TAG_TRK) begin
                r_rd_data <= w_ret;
            end
        end
    end

    assign o_mem_en        = r_mem_en;
    assign o_mem_we        = r_mem_we;
    assign o_mem_addr      = r_mem_addr;
    assign o_mem_wdata     = r_mem_wdata;
    assign o_disp_data     = r_disp_data;
    assign o_disp_valid    = r_disp_valid;
    assign o_rd_data       = r_rd_data;
    assign o_rd_data_valid = r_rd_valid;

endmodule
